clk_rate_sequencer: RTL

CLK_RATE_SEQUENCER -- requirements
Module: clk_rate_sequencer

---
 rtl/clk_rate_pkg.sv | 44 ++++
 rtl/clk_div_core.sv | 38 +++
 rtl/clk_rate_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/clk_rate_pkg.sv
// clk_rate_pkg
// Shared rate table for the clock-rate divider family.
//   NUM_RATES      : number of selectable rates (index 0..NUM_RATES-1)
//   SEL_W / HP_W   : rate-index width and half-period counter width
//   half_period_of : rate index -> half-period count at 100 MHz
//   next_idx/prev_idx : modulo-NUM_RATES stepping of a rate index
package clk_rate_pkg;

  localparam int NUM_RATES = 9;
  localparam int SEL_W     = 4;
  localparam int HP_W      = 26;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } seq_state_t;

  // 50 MHz, 10 MHz, 1 MHz, 100 kHz, 10 kHz, 1 kHz, 100 Hz, 10 Hz, 1 Hz
  function automatic logic [HP_W-1:0] half_period_of(input logic [SEL_W-1:0] idx);
    logic [HP_W-1:0] hp;
    case (idx)
      4'd0:    hp = 26'd1;
      4'd1:    hp = 26'd5;
      4'd2:    hp = 26'd50;
      4'd3:    hp = 26'd500;
      4'd4:    hp = 26'd5_000;
      4'd5:    hp = 26'd50_000;
      4'd6:    hp = 26'd500_000;
      4'd7:    hp = 26'd5_000_000;
      4'd8:    hp = 26'd50_000_000;
      default: hp = 26'd1;
    endcase
    return hp;
  endfunction

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] b);
    return (b >= SEL_W'(NUM_RATES - 1)) ? '0 : b + 4'd1;
  endfunction

  function automatic logic [SEL_W-1:0] prev_idx(input logic [SEL_W-1:0] b);
    return (b == '0) ? SEL_W'(NUM_RATES - 1) : b - 4'd1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core
// Runtime-programmable half-period divider.
//   clk              : system clock
//   rst              : asynchronous active-high reset
//   half_period      : half-period in clk cycles (must be >= 1)
//   clk_out          : divided clock, period 2*half_period, 50 % duty
//   at_fall_boundary : high in the cycle whose edge will drive clk_out low
module clk_div_core
  import clk_rate_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [HP_W-1:0] half_period,
  output logic            clk_out,
  output logic            at_fall_boundary
);

  logic [HP_W-1:0] count;
  logic            at_end;

  // ">=" rather than "==" so a shortened half-period can never strand the
  // counter above its terminal value.
  assign at_end           = (count >= half_period - 26'd1);
  assign at_fall_boundary = clk_out & at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      clk_out <= 1'b0;
    end else if (at_end) begin
      count   <= '0;
      clk_out <= ~clk_out;
    end else begin
      count   <= count + 26'd1;
    end
  end

endmodule

// File: rtl/clk_rate_sequencer.sv
// clk_rate_sequencer
// Selectable-rate clock generator with glitch-free rate switching.
//   CLK100MHZ : 100 MHz system clock
//   RST       : asynchronous active-high reset
//   BTN_NEXT  : async request, rate index +1 (rising edge)
//   BTN_PREV  : async request, rate index -1 (rising edge)
//   AUTO      : async level, sweeps +1 every DWELL_CYCLES when high
//   CLK_OUT   : divided clock at the active rate
//   SEL       : active rate index
//   SWITCHING : a rate change is pending
module clk_rate_sequencer
  import clk_rate_pkg::*;
#(
  parameter int INIT_SEL     = 5,
  parameter int DWELL_CYCLES = 200_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  input  logic             BTN_NEXT,
  input  logic             BTN_PREV,
  input  logic             AUTO,
  output logic             CLK_OUT,
  output logic [SEL_W-1:0] SEL,
  output logic             SWITCHING
);

  localparam logic [SEL_W-1:0] INIT_IDX   = SEL_W'(INIT_SEL);
  localparam logic [31:0]      DWELL_LAST = 32'(DWELL_CYCLES - 1);

  // bit 0 = NEXT, bit 1 = PREV, bit 2 = AUTO
  logic [2:0] sync_meta;
  logic [2:0] sync_out;
  logic [1:0] btn_last;
  logic       next_edge;
  logic       prev_edge;
  logic       auto_on;

  logic [31:0] dwell;
  logic        dwell_req;

  logic             req_valid;
  logic             req_up;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] req_target;

  seq_state_t       state;
  logic [SEL_W-1:0] target;
  logic [HP_W-1:0]  half_period;
  logic             at_fall;

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      sync_meta <= '0;
      sync_out  <= '0;
      btn_last  <= '0;
    end else begin
      sync_meta <= {AUTO, BTN_PREV, BTN_NEXT};
      sync_out  <= sync_meta;
      btn_last  <= sync_out[1:0];
    end
  end

  assign next_edge = sync_out[0] & ~btn_last[0];
  assign prev_edge = sync_out[1] & ~btn_last[1];
  assign auto_on   = sync_out[2];

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      dwell <= '0;
    end else if (!auto_on || dwell == DWELL_LAST) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + 32'd1;
    end
  end

  assign dwell_req = auto_on & (dwell == DWELL_LAST);

  // A dwell tick masks any coincident button edge; NEXT+PREV together cancel.
  always_comb begin
    req_valid = 1'b0;
    req_up    = 1'b0;
    if (dwell_req) begin
      req_valid = 1'b1;
      req_up    = 1'b1;
    end else if (next_edge ^ prev_edge) begin
      req_valid = 1'b1;
      req_up    = next_edge;
    end
  end

  // Requests made while pending step from the pending target, not SEL.
  assign base       = SWITCHING ? target : SEL;
  assign req_target = req_up ? next_idx(base) : prev_idx(base);

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      state     <= ST_RUN;
      target    <= INIT_IDX;
      SEL       <= INIT_IDX;
      SWITCHING <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (req_valid && req_target != SEL) begin
            target    <= req_target;
            state     <= ST_PEND;
            SWITCHING <= 1'b1;
          end
        end
        ST_PEND: begin
          // Swap only at the end of a high half so CLK_OUT falls and the
          // following low half is already timed with the new half-period.
          if (at_fall) begin
            SEL       <= req_valid ? req_target : target;
            target    <= req_valid ? req_target : target;
            state     <= ST_RUN;
            SWITCHING <= 1'b0;
          end else if (req_valid) begin
            target <= req_target;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign half_period = half_period_of(SEL);

  clk_div_core u_div (
    .clk              (CLK100MHZ),
    .rst              (RST),
    .half_period      (half_period),
    .clk_out          (CLK_OUT),
    .at_fall_boundary (at_fall)
  );

endmodule
